issue_unit: RTL and testbench

- Per-SM instruction issue arbiter, directly downstream of the per-warp instruction buffers.
- Each cycle it picks one warp whose IBuffer head is ready (dependency-free, scoreboard not full) and grants it. The granted IBuffer then drives its head instruction to the Operand Collector.
- Round-robin fairness across warps.
- Branch stall: a warp that issues BEQ/BLT is blocked from further issue until SIMT reports the branch resolved.

---
 rtl/issue_unit.sv | 54 +++++
 tb/tb_issue_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// issue_unit: round-robin warp issue arbiter with per-warp branch stall.
module issue_unit #(
    parameter int NUM_WARPS    = 8,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WARPS-1:0]    req_IB_IU,
    input  logic [NUM_WARPS-1:0]    branch_IB_IU,
    input  logic                    stall_OC_IU,
    input  logic                    resolve_SIMT_IU,
    input  logic [LOGNUM_WARPS-1:0] resolve_warpID_SIMT_IU,
    output logic [NUM_WARPS-1:0]    grt_IU_IB,
    output logic                    valid_IU_OC,
    output logic [LOGNUM_WARPS-1:0] warpID_IU_OC,
    output logic [NUM_WARPS-1:0]    branch_pending_IU
);
    logic [LOGNUM_WARPS-1:0] rr_ptr, idx, gid;
    logic [NUM_WARPS-1:0]    pend, elig, set, clr;
    logic                    hit;

    always_comb begin
        elig = req_IB_IU & ~pend;
        idx  = '0;
        gid  = '0;
        hit  = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = LOGNUM_WARPS'((32'(rr_ptr) + 32'(i)) % NUM_WARPS);
            if (!hit && elig[idx]) begin
                hit = 1'b1;
                gid = idx;
            end
        end
    end

    // rst gates the grant so an asserted reset kills it without waiting for an edge
    assign valid_IU_OC       = hit & ~stall_OC_IU & rst;
    assign warpID_IU_OC      = valid_IU_OC ? gid : '0;
    assign grt_IU_IB         = valid_IU_OC ? NUM_WARPS'(1) << gid : '0;
    assign branch_pending_IU = pend;
    assign set               = grt_IU_IB & branch_IB_IU;
    assign clr               = resolve_SIMT_IU ? NUM_WARPS'(1) << resolve_warpID_SIMT_IU : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            pend   <= '0;
        end else begin
            if (valid_IU_OC)
                rr_ptr <= (gid == LOGNUM_WARPS'(NUM_WARPS - 1)) ? '0 : gid + 1'b1;
            pend <= (pend & ~clr) | set;
        end
    end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_issue_unit;
    logic       clk, rst;
    logic [7:0] req, br;
    logic       stall, res;
    logic [2:0] rid;
    logic [7:0] grt, bpend;
    logic       valid;
    logic [2:0] wid;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] grt;
        logic       v;
        logic [2:0] id;
        logic [7:0] pend;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass  = 0;

    issue_unit dut (
        .clk(clk), .rst(rst),
        .req_IB_IU(req), .branch_IB_IU(br), .stall_OC_IU(stall),
        .resolve_SIMT_IU(res), .resolve_warpID_SIMT_IU(rid),
        .grt_IU_IB(grt), .valid_IU_OC(valid), .warpID_IU_OC(wid),
        .branch_pending_IU(bpend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if ({grt, valid, wid, bpend} === {e.grt, e.v, e.id, e.pend})
                n_pass++;
            else
                $display("FAIL step tag=%0d: got grt=%h valid=%b id=%0d pend=%h, want grt=%h valid=%b id=%0d pend=%h",
                         e.tag, grt, valid, wid, bpend, e.grt, e.v, e.id, e.pend);
            if (valid === 1'b1) begin
                n_total++;
                if (bpend[wid] === 1'b0) n_pass++;
                else $display("FAIL grant_to_pending tag=%0d: granted warp %0d with pend=%h, want pend bit 0", e.tag, wid, bpend);
            end
        end else if (valid !== 1'b0) begin
            n_total++;
            $display("FAIL unexpected_grant: valid=%b id=%0d, want no grant", valid, wid);
        end
    end

    task automatic step(input logic [7:0] r, b, input logic s, rs, input logic [2:0] ri,
                        input logic [7:0] tag, input logic v, input logic [2:0] id, input logic [7:0] p);
        req = r; br = b; stall = s; res = rs; rid = ri;
        q.push_back('{tag, v ? 8'd1 << id : 8'h00, v, id, p});
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; req = '0; br = '0; stall = 1'b0; res = 1'b0; rid = '0;
        @(posedge clk); #1;
        // reset holds everything quiet even with all requests up
        step(8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(8'hFF, 8'h00, 0, 0, 0, 1, 1, 3'(i % 8), 8'h00);
        // rr_ptr=2 -> 6 via warp5, then sparse wrap
        step(8'h20, 8'h00, 0, 0, 0, 2, 1, 5, 8'h00);
        step(8'h05, 8'h00, 0, 0, 0, 2, 1, 0, 8'h00);
        step(8'h05, 8'h00, 0, 0, 0, 2, 1, 2, 8'h00);
        step(8'h05, 8'h00, 0, 0, 0, 2, 1, 0, 8'h00);
        // rr_ptr=1 -> 0 via warp7, then branch stall on warp0
        step(8'h80, 8'h00, 0, 0, 0, 3, 1, 7, 8'h00);
        step(8'h03, 8'h01, 0, 0, 0, 3, 1, 0, 8'h00);
        step(8'h03, 8'h01, 0, 0, 0, 3, 1, 1, 8'h01);
        step(8'h03, 8'h01, 0, 0, 0, 3, 1, 1, 8'h01);
        step(8'h03, 8'h01, 0, 1, 0, 3, 1, 1, 8'h01);
        step(8'h03, 8'h00, 0, 0, 0, 3, 1, 0, 8'h00);
        // rr_ptr=1 -> 3 via warp2, then OC stall
        step(8'h04, 8'h00, 0, 0, 0, 4, 1, 2, 8'h00);
        for (int i = 0; i < 4; i++) step(8'hFF, 8'h00, 1, 0, 0, 4, 0, 0, 8'h00);
        step(8'hFF, 8'h00, 0, 0, 0, 4, 1, 3, 8'h00);
        // spurious resolve, build pend=0A, then async reset mid-cycle
        step(8'h00, 8'h00, 0, 1, 5, 5, 0, 0, 8'h00);
        step(8'h00, 8'h00, 0, 0, 0, 5, 0, 0, 8'h00);
        step(8'h08, 8'h08, 0, 0, 0, 5, 1, 3, 8'h00);
        step(8'h02, 8'h02, 0, 0, 0, 5, 1, 1, 8'h08);
        step(8'hFF, 8'h00, 0, 0, 0, 5, 1, 2, 8'h0A);
        req = 8'hFF; br = 8'h00; stall = 1'b0; res = 1'b0;
        #1 rst = 1'b0;
        q.push_back('{8'd5, 8'h00, 1'b0, 3'd0, 8'h00});
        @(posedge clk); #1 rst = 1'b1;
        // every warp takes a branch, then only the resolved one issues
        for (int i = 0; i < 8; i++) step(8'hFF, 8'hFF, 0, 0, 0, 6, 1, 3'(i), 8'((1 << i) - 1));
        for (int i = 0; i < 3; i++) step(8'hFF, 8'hFF, 0, 0, 0, 6, 0, 0, 8'hFF);
        step(8'hFF, 8'hFF, 0, 1, 4, 6, 0, 0, 8'hFF);
        step(8'hFF, 8'h00, 0, 0, 0, 6, 1, 4, 8'hEF);
        step(8'hFF, 8'h00, 0, 0, 0, 6, 1, 4, 8'hEF);
        step(8'h00, 8'h00, 0, 0, 0, 6, 0, 0, 8'hEF);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
